// File: rtl/temp_mon_pkg.sv
// Shared types and constants for the multi-channel temperature monitor.
package temp_mon_pkg;

  typedef enum logic {
    HYST_NORMAL = 1'b0,
    HYST_WARN   = 1'b1
  } hyst_state_e;

  localparam int CFG_BYTE_W = 8;

  // Fill bits for the reset thresholds; replicate to the threshold width at use.
  localparam logic THR_HI_RST_BIT = 1'b1;
  localparam logic THR_LO_RST_BIT = 1'b0;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hyst_channel.sv
// One channel's byte-loaded thresholds and NORMAL/WARN hysteresis FSM.
// STICKY_WARN_EN adds a latched warning bit with a per-channel clear.
module hyst_channel
  import temp_mon_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  i_eval,
  input  logic [W-1:0]          i_avg,
  input  logic                  i_cfg_wr,
  input  logic                  i_cfg_hi,
  input  logic [CFG_BYTE_W-1:0] i_cfg_byte,
`ifdef STICKY_WARN_EN
  input  logic                  i_warn_clr,
  output logic                  o_warn_sticky,
`endif
  output logic                  o_warn,
  output logic                  o_warn_nxt
);

  logic [W-1:0] r_thr_hi;
  logic [W-1:0] r_thr_lo;
  logic [W-1:0] w_thr_hi_nxt;
  logic [W-1:0] w_thr_lo_nxt;
  hyst_state_e  r_state;
  hyst_state_e  w_state_nxt;

  // New byte enters at the top, so W/8 writes leave the first byte at the bottom.
  always_comb begin
    w_thr_hi_nxt = W'({i_cfg_byte, r_thr_hi} >> CFG_BYTE_W);
    w_thr_lo_nxt = W'({i_cfg_byte, r_thr_lo} >> CFG_BYTE_W);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_thr_hi <= {W{THR_HI_RST_BIT}};
      r_thr_lo <= {W{THR_LO_RST_BIT}};
    end else if (i_cfg_wr) begin
      if (i_cfg_hi) r_thr_hi <= w_thr_hi_nxt;
      else          r_thr_lo <= w_thr_lo_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) r_state <= HYST_NORMAL;
    else        r_state <= w_state_nxt;
  end

  // Compares against the registered thresholds, so a same-cycle write applies later.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      HYST_NORMAL: if (i_eval && (i_avg >= r_thr_hi)) w_state_nxt = HYST_WARN;
      HYST_WARN:   if (i_eval && (i_avg <= r_thr_lo) && (i_avg < r_thr_hi))
                     w_state_nxt = HYST_NORMAL;
    endcase
  end

  assign o_warn     = (r_state == HYST_WARN);
  assign o_warn_nxt = (w_state_nxt == HYST_WARN);

`ifdef STICKY_WARN_EN
  logic r_sticky;

  always_ff @(posedge clk_in) begin
    if (!rst_n)                                                      r_sticky <= 1'b0;
    else if ((r_state == HYST_NORMAL) && (w_state_nxt == HYST_WARN)) r_sticky <= 1'b1;
    else if (i_warn_clr)                                             r_sticky <= 1'b0;
  end

  assign o_warn_sticky = r_sticky;
`endif

endmodule

// File: rtl/multi_ch_hyst_monitor.sv
// Multi-channel sample averager feeding per-channel hysteresis monitors.
// Optional build macro: STICKY_WARN_EN (adds warn_clr / warn_sticky).
module multi_ch_hyst_monitor
  import temp_mon_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   sample_valid,
  input  logic [ch_w(NCH)-1:0]   sample_ch,
  input  logic [W-1:0]           sample_data,
  input  logic                   cfg_valid,
  input  logic [ch_w(NCH)-1:0]   cfg_ch,
  input  logic                   cfg_hi,
  input  logic [CFG_BYTE_W-1:0]  cfg_byte,
`ifdef STICKY_WARN_EN
  input  logic [NCH-1:0]         warn_clr,
  output logic [NCH-1:0]         warn_sticky,
`endif
  output logic                   avg_valid,
  output logic [ch_w(NCH)-1:0]   avg_ch,
  output logic [W-1:0]           avg_data,
  output logic [NCH-1:0]         warn,
  output logic                   warn_any
);

  localparam int CH_W  = ch_w(NCH);
  localparam int ACC_W = W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  // With AVG_LOG2 == 0 the counter never leaves 0, so every sample completes.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] r_acc [NCH];
  logic [CNT_W-1:0] r_cnt [NCH];
  logic             r_avg_valid;
  logic [CH_W-1:0]  r_avg_ch;
  logic [W-1:0]     r_avg_data;
  logic             r_warn_any;

  logic             w_sample_ok;
  logic             w_complete;
  logic [ACC_W-1:0] w_sum;
  logic [W-1:0]     w_avg;
  logic [NCH-1:0]   w_eval;
  logic [NCH-1:0]   w_cfg_wr;
  logic [NCH-1:0]   w_warn_nxt;

  always_comb begin
    w_sample_ok = sample_valid && (32'(sample_ch) < 32'(NCH));
    w_sum       = r_acc[sample_ch] + ACC_W'(sample_data);
    w_complete  = w_sample_ok && (r_cnt[sample_ch] == CNT_LAST);
    w_avg       = W'(w_sum >> AVG_LOG2);
    w_eval      = '0;
    w_cfg_wr    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_eval[i]   = w_complete && (32'(sample_ch) == i);
      w_cfg_wr[i] = cfg_valid && (32'(cfg_ch) == i);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
      end
      r_avg_valid <= 1'b0;
      r_avg_ch    <= '0;
      r_avg_data  <= '0;
      r_warn_any  <= 1'b0;
    end else begin
      r_avg_valid <= w_complete;
      r_warn_any  <= |w_warn_nxt;
      if (w_complete) begin
        r_avg_ch   <= sample_ch;
        r_avg_data <= w_avg;
      end
      if (w_sample_ok) begin
        if (w_complete) begin
          r_acc[sample_ch] <= '0;
          r_cnt[sample_ch] <= '0;
        end else begin
          r_acc[sample_ch] <= w_sum;
          r_cnt[sample_ch] <= r_cnt[sample_ch] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    hyst_channel #(.W(W)) u_ch (
      .clk_in        (clk_in),
      .rst_n         (rst_n),
      .i_eval        (w_eval[g]),
      .i_avg         (w_avg),
      .i_cfg_wr      (w_cfg_wr[g]),
      .i_cfg_hi      (cfg_hi),
      .i_cfg_byte    (cfg_byte),
`ifdef STICKY_WARN_EN
      .i_warn_clr    (warn_clr[g]),
      .o_warn_sticky (warn_sticky[g]),
`endif
      .o_warn        (warn[g]),
      .o_warn_nxt    (w_warn_nxt[g])
    );
  end

  assign avg_valid = r_avg_valid;
  assign avg_ch    = r_avg_ch;
  assign avg_data  = r_avg_data;
  assign warn_any  = r_warn_any;

endmodule

// File: tb/tb_multi_ch_hyst_monitor.sv
// Bench for multi_ch_hyst_monitor: vector table, corner sequences, random vs. reference model.
module tb_multi_ch_hyst_monitor;

  localparam int NCH  = 4;
  localparam int NAVG = 8;

  logic        clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_n;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic [15:0] sample_data;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic        cfg_hi;
  logic [7:0]  cfg_byte;
  logic        avg_valid;
  logic [1:0]  avg_ch;
  logic [15:0] avg_data;
  logic [3:0]  warn;
  logic        warn_any;
`ifdef STICKY_WARN_EN
  logic [3:0]  warn_clr;
  logic [3:0]  warn_sticky;
`endif

  multi_ch_hyst_monitor #(.NCH(4), .W(16), .AVG_LOG2(3)) u_dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .cfg_valid    (cfg_valid),
    .cfg_ch       (cfg_ch),
    .cfg_hi       (cfg_hi),
    .cfg_byte     (cfg_byte),
`ifdef STICKY_WARN_EN
    .warn_clr     (warn_clr),
    .warn_sticky  (warn_sticky),
`endif
    .avg_valid    (avg_valid),
    .avg_ch       (avg_ch),
    .avg_data     (avg_data),
    .warn         (warn),
    .warn_any     (warn_any)
  );

  // Six-channel instance exercising non-power-of-two channel range.
  logic        rst6_n;
  logic        s6_valid;
  logic [2:0]  s6_ch;
  logic [15:0] s6_data;
  logic        a6_valid;
  logic [2:0]  a6_ch;
  logic [15:0] a6_data;
  logic [5:0]  w6;
  logic        w6_any;
`ifdef STICKY_WARN_EN
  logic [5:0]  sticky6;
`endif

  multi_ch_hyst_monitor #(.NCH(6), .W(16), .AVG_LOG2(3)) u_dut6 (
    .clk_in       (clk_in),
    .rst_n        (rst6_n),
    .sample_valid (s6_valid),
    .sample_ch    (s6_ch),
    .sample_data  (s6_data),
    .cfg_valid    (1'b0),
    .cfg_ch       (3'd0),
    .cfg_hi       (1'b0),
    .cfg_byte     (8'd0),
`ifdef STICKY_WARN_EN
    .warn_clr     (6'd0),
    .warn_sticky  (sticky6),
`endif
    .avg_valid    (a6_valid),
    .avg_ch       (a6_ch),
    .avg_data     (a6_data),
    .warn         (w6),
    .warn_any     (w6_any)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: raw sample lists per channel, averaged when full.
  int unsigned m_samps[NCH][$];
  int unsigned m_hi[NCH];
  int unsigned m_lo[NCH];
  bit          m_warn[NCH];
  bit          m_sticky[NCH];
  bit          e_valid;
  int unsigned e_ch;
  int unsigned e_data;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_samps[i].delete();
      m_hi[i]     = 32'hFFFF;
      m_lo[i]     = 0;
      m_warn[i]   = 1'b0;
      m_sticky[i] = 1'b0;
    end
    e_valid = 1'b0;
    e_ch    = 0;
    e_data  = 0;
  endfunction

  function automatic void model_step(input bit sv, input int unsigned ch, input int unsigned d,
                                     input bit cv, input int unsigned cch, input bit chi,
                                     input int unsigned cbyte, input logic [3:0] clr);
    bit          set_now[NCH];
    int unsigned sum;
    for (int i = 0; i < NCH; i++) set_now[i] = 1'b0;
    e_valid = 1'b0;
    if (sv && ch < NCH) begin
      m_samps[ch].push_back(d);
      if (m_samps[ch].size() == NAVG) begin
        sum = 0;
        for (int k = 0; k < NAVG; k++) sum += m_samps[ch][k];
        e_valid = 1'b1;
        e_ch    = ch;
        e_data  = sum / NAVG;
        if (!m_warn[ch]) begin
          if (e_data >= m_hi[ch]) begin
            m_warn[ch]  = 1'b1;
            set_now[ch] = 1'b1;
          end
        end else if (e_data <= m_lo[ch] && e_data < m_hi[ch]) begin
          m_warn[ch] = 1'b0;
        end
        m_samps[ch].delete();
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (clr[i]) m_sticky[i] = 1'b0;
      if (set_now[i]) m_sticky[i] = 1'b1;
    end
    if (cv && cch < NCH) begin
      if (chi) m_hi[cch] = ((m_hi[cch] >> 8) | (cbyte << 8)) & 32'hFFFF;
      else     m_lo[cch] = ((m_lo[cch] >> 8) | (cbyte << 8)) & 32'hFFFF;
    end
  endfunction

  function automatic logic [3:0] m_warn_vec();
    logic [3:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_warn[i];
    return v;
  endfunction

  function automatic logic [3:0] m_sticky_vec();
    logic [3:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_sticky[i];
    return v;
  endfunction

  task automatic check_model(input string tag);
    check($sformatf("%s_avg_valid", tag), avg_valid, e_valid);
    check($sformatf("%s_avg_ch", tag), avg_ch, e_ch);
    check($sformatf("%s_avg_data", tag), avg_data, e_data);
    check($sformatf("%s_warn", tag), warn, m_warn_vec());
    check($sformatf("%s_warn_any", tag), warn_any, |m_warn_vec());
`ifdef STICKY_WARN_EN
    check($sformatf("%s_warn_sticky", tag), warn_sticky, m_sticky_vec());
`endif
  endtask

  task automatic idle_inputs();
    sample_valid = 1'b0;
    sample_ch    = '0;
    sample_data  = '0;
    cfg_valid    = 1'b0;
    cfg_ch       = '0;
    cfg_hi       = 1'b0;
    cfg_byte     = '0;
`ifdef STICKY_WARN_EN
    warn_clr     = '0;
`endif
  endtask

  task automatic drive(input bit sv, input int unsigned ch, input int unsigned d,
                       input bit cv, input int unsigned cch, input bit chi,
                       input int unsigned cbyte, input logic [3:0] clr, input string tag);
    sample_valid = sv;
    sample_ch    = ch[1:0];
    sample_data  = d[15:0];
    cfg_valid    = cv;
    cfg_ch       = cch[1:0];
    cfg_hi       = chi;
    cfg_byte     = cbyte[7:0];
`ifdef STICKY_WARN_EN
    warn_clr     = clr;
`endif
    model_step(sv, ch, d, cv, cch, chi, cbyte, clr);
    @(posedge clk_in);
    #1;
    idle_inputs();
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_in);
    #1;
    model_reset();
    check_model("reset");
    rst_n = 1'b1;
  endtask

  task automatic drive6(input bit sv, input int unsigned ch, input int unsigned d);
    s6_valid = sv;
    s6_ch    = ch[2:0];
    s6_data  = d[15:0];
    @(posedge clk_in);
    #1;
    s6_valid = 1'b0;
  endtask

  typedef struct {
    bit          sv;
    int unsigned ch;
    int unsigned data;
    bit          cv;
    int unsigned cch;
    bit          chi;
    int unsigned cbyte;
    bit          ev;
    int unsigned ech;
    int unsigned edata;
    logic [3:0]  ewarn;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit sv, input int unsigned ch, input int unsigned data,
                              input bit cv, input int unsigned cch, input bit chi,
                              input int unsigned cbyte, input bit ev, input int unsigned ech,
                              input int unsigned edata, input logic [3:0] ewarn);
    vec_t v;
    v.sv = sv; v.ch = ch; v.data = data; v.cv = cv; v.cch = cch; v.chi = chi;
    v.cbyte = cbyte; v.ev = ev; v.ech = ech; v.edata = edata; v.ewarn = ewarn;
    tbl.push_back(v);
  endfunction

  initial begin
    int unsigned avgs[4];
    logic [3:0]  wexp[4];
    int unsigned p_ch;
    int unsigned p_data;
    logic [3:0]  p_w;
    bit          last;

    rst_n    = 1'b0;
    rst6_n   = 1'b0;
    s6_valid = 1'b0;
    s6_ch    = '0;
    s6_data  = '0;
    idle_inputs();

    // Eight 0x1000 samples on ch2 with default thresholds.
    for (int k = 0; k < 8; k++) begin
      last = (k == 7);
      add(1, 2, 32'h1000, 0, 0, 0, 0, last, last ? 2 : 0, last ? 32'h1000 : 0, 4'b0000);
    end
    // ch1 thresholds: hi = 0x0800, lo = 0x0600, LSB byte first.
    add(0, 0, 0, 1, 1, 1, 32'h00, 0, 2, 32'h1000, 4'b0000);
    add(0, 0, 0, 1, 1, 1, 32'h08, 0, 2, 32'h1000, 4'b0000);
    add(0, 0, 0, 1, 1, 0, 32'h00, 0, 2, 32'h1000, 4'b0000);
    add(0, 0, 0, 1, 1, 0, 32'h06, 0, 2, 32'h1000, 4'b0000);
    avgs = '{32'h0700, 32'h0800, 32'h0700, 32'h0600};
    wexp = '{4'b0000, 4'b0010, 4'b0010, 4'b0000};
    p_ch = 2; p_data = 32'h1000; p_w = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 8; k++) begin
        last = (k == 7);
        add(1, 1, avgs[j], 0, 0, 0, 0, last, last ? 1 : p_ch, last ? avgs[j] : p_data,
            last ? wexp[j] : p_w);
      end
      p_ch = 1; p_data = avgs[j]; p_w = wexp[j];
    end

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].sv, tbl[i].ch, tbl[i].data, tbl[i].cv, tbl[i].cch, tbl[i].chi,
            tbl[i].cbyte, 4'b0000, "tbl_model");
      check($sformatf("tbl%0d_avg_valid", i), avg_valid, tbl[i].ev);
      check($sformatf("tbl%0d_avg_ch", i), avg_ch, tbl[i].ech);
      check($sformatf("tbl%0d_avg_data", i), avg_data, tbl[i].edata);
      check($sformatf("tbl%0d_warn", i), warn, tbl[i].ewarn);
      check($sformatf("tbl%0d_warn_any", i), warn_any, |tbl[i].ewarn);
    end

    // Interleaved ch0 (0..7) and ch3 (100..107): consecutive completions.
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, k, 0, 0, 0, 0, 4'b0000, "ilv0");
      if (k == 7) begin
        check("ilv_ch0_valid", avg_valid, 1);
        check("ilv_ch0_ch", avg_ch, 0);
        check("ilv_ch0_data", avg_data, 3);
      end
      drive(1, 3, 100 + k, 0, 0, 0, 0, 4'b0000, "ilv3");
      if (k == 7) begin
        check("ilv_ch3_valid", avg_valid, 1);
        check("ilv_ch3_ch", avg_ch, 3);
        check("ilv_ch3_data", avg_data, 103);
      end
    end

    // ch0 thr_hi = 0x0100, then a same-cycle write of 0x10 with the completing sample.
    drive(0, 0, 0, 1, 0, 1, 32'h00, 4'b0000, "sc_cfg");
    drive(0, 0, 0, 1, 0, 1, 32'h01, 4'b0000, "sc_cfg");
    for (int k = 0; k < 7; k++) drive(1, 0, 32'h0200, 0, 0, 0, 0, 4'b0000, "sc_acc");
    drive(1, 0, 32'h0200, 1, 0, 1, 32'h10, 4'b0000, "sc_done");
    check("same_cycle_old_thr_warn0", warn[0], 1'b1);
`ifdef STICKY_WARN_EN
    check("sticky_set", warn_sticky[0], 1'b1);
`endif
    for (int k = 0; k < 8; k++) drive(1, 0, 0, 0, 0, 0, 0, 4'b0000, "sc_zero");
    check("return_normal_warn0", warn[0], 1'b0);
`ifdef STICKY_WARN_EN
    check("sticky_survives", warn_sticky[0], 1'b1);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 4'b0001, "sc_clr");
`ifdef STICKY_WARN_EN
    check("sticky_cleared", warn_sticky[0], 1'b0);
`endif
    for (int k = 0; k < 7; k++) drive(1, 0, 32'h1000, 0, 0, 0, 0, 4'b0000, "sc_new");
    drive(1, 0, 32'h1000, 0, 0, 0, 0, 4'b0000, "sc_new_done");
    check("new_thr_0x1001_no_warn", warn[0], 1'b0);
    for (int k = 0; k < 8; k++) drive(1, 0, 32'h1001, 0, 0, 0, 0, 4'b0000, "sc_new2");
    check("new_thr_0x1001_warn", warn[0], 1'b1);

    // Six-channel instance: ch5 valid, ch6/ch7 ignored, reset discards partial sums.
    repeat (2) @(posedge clk_in);
    #1;
    check("d6_reset_valid", a6_valid, 0);
    check("d6_reset_data", a6_data, 0);
    rst6_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive6(1, 5, 32'h55);
      check($sformatf("d6_ch5_valid%0d", k), a6_valid, (k == 7));
    end
    check("d6_ch5_ch", a6_ch, 5);
    check("d6_ch5_data", a6_data, 32'h55);
    for (int k = 0; k < 4; k++) drive6(1, 5, 32'h100);
    for (int k = 0; k < 10; k++) begin
      drive6(1, (k % 2 == 0) ? 7 : 6, 32'hFFFF);
      check($sformatf("d6_oor_valid%0d", k), a6_valid, 0);
    end
    check("d6_oor_hold_ch", a6_ch, 5);
    check("d6_oor_hold_data", a6_data, 32'h55);
    for (int k = 0; k < 4; k++) drive6(1, 5, 32'h100);
    check("d6_after_oor_valid", a6_valid, 1);
    check("d6_after_oor_data", a6_data, 32'h100);
    for (int k = 0; k < 4; k++) drive6(1, 5, 32'h1000);
    rst6_n = 1'b0;
    @(posedge clk_in);
    #1;
    rst6_n = 1'b1;
    check("d6_midreset_data", a6_data, 0);
    for (int k = 0; k < 8; k++) begin
      drive6(1, 5, 32'h10);
      check($sformatf("d6_post_reset_valid%0d", k), a6_valid, (k == 7));
    end
    check("d6_post_reset_data", a6_data, 32'h10);
    check("d6_warn_none", w6, 0);

    // Randomized traffic checked against the reference model every cycle.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [3:0] clr;
      clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
`ifndef STICKY_WARN_EN
      clr = 4'b0000;
`endif
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 65535),
            $urandom_range(0, 4) == 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
            $urandom_range(0, 255), clr, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
